pbus_arbiter: RTL and testbench

//  Two-master arbiter in front of the 8-bit Wishbone peripheral bus (4 KB window: IO, config, SYSCALL, SPM).

---
 rtl/pbus_pkg.sv | 11 +
 rtl/pbus_arbiter_if.sv | 19 +
 rtl/pbus_watchdog.sv | 36 +++
 rtl/pbus_arbiter.sv | 109 ++++++++++
 tb/tb_pbus_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pbus_pkg.sv
// Shared constants and arbiter state encoding for the peripheral bus arbiter.
package pbus_pkg;
  localparam int unsigned PBUS_ADDR_W = 12;
  localparam int unsigned PBUS_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;
endpackage

// File: rtl/pbus_arbiter_if.sv
// Wishbone-style peripheral bus link; master drives the request, slave returns data/ack/err.
interface pbus_arbiter_if
  import pbus_pkg::*;
#(
  parameter int unsigned ADDR_W = PBUS_ADDR_W,
  parameter int unsigned DATA_W = PBUS_DATA_W
);
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              we;
  logic              cyc;
  logic              stb;
  logic              ack;
  logic              err;

  modport master (output adr, dat_w, we, cyc, stb, input dat_r, ack, err);
  modport slave  (input adr, dat_w, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/pbus_watchdog.sv
// Bus watchdog: counts unacknowledged strobe cycles and flags expiry for one cycle.
module pbus_watchdog
  import pbus_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  input  logic owner_chg,
  output logic expire,
  output logic kill
);
  localparam int unsigned CNT_W = $clog2(TMO_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TMO_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt;

  // ACK in the expiry cycle wins, so expiry requires ~ack
  assign expire = stb & ~ack & (wd_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      kill   <= 1'b0;
    end else begin
      kill <= expire;
      if (!stb || ack || owner_chg || expire) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/pbus_arbiter.sv
// Two-master round-robin arbiter for the peripheral bus with a hung-cycle watchdog.
module pbus_arbiter
  import pbus_pkg::*;
#(
  parameter int unsigned ADDR_W     = PBUS_ADDR_W,
  parameter int unsigned DATA_W     = PBUS_DATA_W,
  parameter int unsigned TMO_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  pbus_arbiter_if.slave  m0,
  pbus_arbiter_if.slave  m1,
  pbus_arbiter_if.master s,
  output logic           tmo_int
);
  arb_state_e        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              expire, kill, owner_chg;
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic              we_o, cyc_o, stb_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || last_gnt_q)) begin
          state_d    = OWN0;
          last_gnt_d = 1'b0;
        end else if (m1.cyc) begin
          state_d    = OWN1;
          last_gnt_d = 1'b1;
        end
      end
      OWN0:    if (!m0.cyc) state_d = IDLE;
      OWN1:    if (!m1.cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign owner_chg = (state_d != state_q);

  always_comb begin
    adr_o    = '0;
    dat_o    = '0;
    we_o     = 1'b0;
    cyc_o    = 1'b0;
    stb_o    = 1'b0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.dat_r = '0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.dat_r = '0;
    case (state_q)
      OWN0: begin
        adr_o    = m0.adr;
        dat_o    = m0.dat_w;
        we_o     = m0.we;
        cyc_o    = m0.cyc;
        stb_o    = m0.stb & ~kill;
        m0.ack   = s.ack & stb_o;
        m0.err   = expire;
        m0.dat_r = s.dat_r;
      end
      OWN1: begin
        adr_o    = m1.adr;
        dat_o    = m1.dat_w;
        we_o     = m1.we;
        cyc_o    = m1.cyc;
        stb_o    = m1.stb & ~kill;
        m1.ack   = s.ack & stb_o;
        m1.err   = expire;
        m1.dat_r = s.dat_r;
      end
      default: ;
    endcase
  end

  assign s.adr   = adr_o;
  assign s.dat_w = dat_o;
  assign s.we    = we_o;
  assign s.cyc   = cyc_o;
  assign s.stb   = stb_o;
  assign tmo_int = expire;

  pbus_watchdog #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .stb       (stb_o),
    .ack       (s.ack),
    .owner_chg (owner_chg),
    .expire    (expire),
    .kill      (kill)
  );
endmodule

// File: tb/tb_pbus_arbiter.sv
// Directed scoreboard bench for pbus_arbiter: arbitration, locking, watchdog expiry and reset.
module tb_pbus_arbiter;
  import pbus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tmo_int;

  pbus_arbiter_if #(.ADDR_W(12), .DATA_W(8)) m0_bus ();
  pbus_arbiter_if #(.ADDR_W(12), .DATA_W(8)) m1_bus ();
  pbus_arbiter_if #(.ADDR_W(12), .DATA_W(8)) s_bus ();

  pbus_arbiter #(
    .ADDR_W(12),
    .DATA_W(8),
    .TMO_CYCLES(64)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus),
    .tmo_int (tmo_int)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];

  function automatic logic [63:0] ev(input logic cyc, input logic stb, input logic we,
                                     input logic [11:0] adr, input logic [7:0] dw,
                                     input logic a0, input logic e0, input logic [7:0] d0,
                                     input logic a1, input logic e1, input logic [7:0] d1,
                                     input logic tmo);
    return {20'h0, tmo, e1, a1, d1, e0, a0, d0, dw, adr, we, stb, cyc};
  endfunction

  function automatic logic [63:0] obs();
    return {20'h0, tmo_int, m1_bus.err, m1_bus.ack, m1_bus.dat_r,
            m0_bus.err, m0_bus.ack, m0_bus.dat_r,
            s_bus.dat_w, s_bus.adr, s_bus.we, s_bus.stb, s_bus.cyc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // push the expectation, then compare against the DUT at the falling edge
  task automatic expect_at_negedge(input string tag, input logic [63:0] e);
    string       t;
    logic [63:0] x;
    logic [63:0] o;
    tag_q.push_back(tag);
    exp_q.push_back(e);
    @(negedge clk);
    t = tag_q.pop_front();
    x = exp_q.pop_front();
    o = obs();
    vectors++;
    assert (o === x) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", t, o, x);
    end
  endtask

  task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                          input logic [11:0] adr, input logic [7:0] dw);
    m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
    m0_bus.adr = adr; m0_bus.dat_w = dw;
  endtask

  task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                          input logic [11:0] adr, input logic [7:0] dw);
    m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
    m1_bus.adr = adr; m1_bus.dat_w = dw;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  logic [63:0] zero;
  logic [11:0] a;

  initial begin
    zero = ev(0, 0, 0, 12'h0, 8'h0, 0, 0, 8'h0, 0, 0, 8'h0, 0);
    drive_m0(0, 0, 0, 12'h0, 8'h0);
    drive_m1(0, 0, 0, 12'h0, 8'h0);
    s_bus.ack = 1'b0; s_bus.dat_r = 8'h0; s_bus.err = 1'b0;

    // 1: reset state, then single M0 read with zero-wait ack
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    expect_at_negedge("reset_state", zero);
    tick();
    drive_m0(1, 1, 0, 12'h800, 8'h11);
    s_bus.ack = 1'b1; s_bus.dat_r = 8'h5A;
    expect_at_negedge("t1_grant_latency", zero);
    tick();
    expect_at_negedge("t1_m0_read", ev(1, 1, 0, 12'h800, 8'h11, 1, 0, 8'h5A, 0, 0, 8'h0, 0));
    tick();
    drive_m0(0, 0, 0, 12'h0, 8'h0);
    tick();

    // 2: tie after reset goes to M0, then M1, then alternates back to M0
    rst = 1'b1; tick(); rst = 1'b0;
    drive_m0(1, 1, 1, 12'h010, 8'h01);
    drive_m1(1, 1, 0, 12'h020, 8'h02);
    s_bus.dat_r = 8'h33;
    tick();
    expect_at_negedge("t2_tie_m0", ev(1, 1, 1, 12'h010, 8'h01, 1, 0, 8'h33, 0, 0, 8'h0, 0));
    tick();
    drive_m0(0, 0, 0, 12'h0, 8'h0);
    tick();
    expect_at_negedge("t2_dead_cycle", zero);
    tick();
    expect_at_negedge("t2_m1_granted", ev(1, 1, 0, 12'h020, 8'h02, 0, 0, 8'h0, 1, 0, 8'h33, 0));
    tick();
    drive_m1(0, 0, 0, 12'h0, 8'h0);
    tick();
    drive_m0(1, 1, 1, 12'h011, 8'h03);
    drive_m1(1, 1, 0, 12'h021, 8'h04);
    tick();
    expect_at_negedge("t2_tie_alternates", ev(1, 1, 1, 12'h011, 8'h03, 1, 0, 8'h33, 0, 0, 8'h0, 0));
    tick();
    drive_m0(0, 0, 0, 12'h0, 8'h0);
    drive_m1(0, 0, 0, 12'h0, 8'h0);
    tick();

    // 3: M1 locked burst of four beats, M0 waits without interleaving
    drive_m0(1, 1, 1, 12'h0AA, 8'h0A);
    drive_m1(1, 1, 0, 12'h600, 8'h00);
    s_bus.dat_r = 8'h77;
    tick();
    for (int i = 0; i < 4; i++) begin
      a = 12'h600 + 12'(i);
      m1_bus.adr = a;
      expect_at_negedge($sformatf("t3_beat%0d", i), ev(1, 1, 0, a, 8'h00, 0, 0, 8'h0, 1, 0, 8'h77, 0));
      if (i < 3) tick();
    end
    tick();
    drive_m1(0, 0, 0, 12'h0, 8'h0);
    tick();
    expect_at_negedge("t3_dead_cycle", zero);
    tick();
    expect_at_negedge("t3_m0_after", ev(1, 1, 1, 12'h0AA, 8'h0A, 1, 0, 8'h77, 0, 0, 8'h0, 0));
    tick();
    drive_m0(0, 0, 0, 12'h0, 8'h0);
    tick();

    // 4: watchdog expiry with ACK held low
    s_bus.ack = 1'b0; s_bus.dat_r = 8'h9C;
    drive_m0(1, 1, 0, 12'h123, 8'h00);
    tick();
    expect_at_negedge("t4_first_stb", ev(1, 1, 0, 12'h123, 8'h00, 0, 0, 8'h9C, 0, 0, 8'h0, 0));
    for (int i = 0; i < 62; i++) tick();
    expect_at_negedge("t4_before_expiry", ev(1, 1, 0, 12'h123, 8'h00, 0, 0, 8'h9C, 0, 0, 8'h0, 0));
    tick();
    expect_at_negedge("t4_expiry", ev(1, 1, 0, 12'h123, 8'h00, 0, 1, 8'h9C, 0, 0, 8'h0, 1));
    tick();
    expect_at_negedge("t4_stb_killed", ev(1, 0, 0, 12'h123, 8'h00, 0, 0, 8'h9C, 0, 0, 8'h0, 0));
    tick();
    expect_at_negedge("t4_stb_resumes", ev(1, 1, 0, 12'h123, 8'h00, 0, 0, 8'h9C, 0, 0, 8'h0, 0));
    tick();
    drive_m0(0, 0, 0, 12'h0, 8'h0);
    tick();

    // 5: ACK arriving in the expiry cycle wins over ERR
    drive_m0(1, 1, 1, 12'h456, 8'hE1);
    tick();
    for (int i = 0; i < 63; i++) tick();
    s_bus.ack = 1'b1;
    expect_at_negedge("t5_ack_wins", ev(1, 1, 1, 12'h456, 8'hE1, 1, 0, 8'h9C, 0, 0, 8'h0, 0));
    tick();
    s_bus.ack = 1'b0;
    expect_at_negedge("t5_no_kill", ev(1, 1, 1, 12'h456, 8'hE1, 0, 0, 8'h9C, 0, 0, 8'h0, 0));
    tick();
    drive_m0(0, 0, 0, 12'h0, 8'h0);
    tick();

    // 6: reset during an M1 beat, then the first tie goes to M0
    drive_m1(1, 1, 1, 12'h7FF, 8'hC3);
    s_bus.ack = 1'b1; s_bus.dat_r = 8'h44;
    tick();
    expect_at_negedge("t6_m1_beat", ev(1, 1, 1, 12'h7FF, 8'hC3, 0, 0, 8'h0, 1, 0, 8'h44, 0));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_m0(1, 1, 0, 12'h0F0, 8'h00);
    expect_at_negedge("t6_after_reset", zero);
    tick();
    expect_at_negedge("t6_tie_to_m0", ev(1, 1, 0, 12'h0F0, 8'h00, 1, 0, 8'h44, 0, 0, 8'h0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
